// File: rtl/flex_stp_framer.sv
// flex_stp_framer: serial-to-parallel shift register that frames NUM_BITS-wide
// words, hands each completed word to a consumer through a one-word output
// buffer with a valid/ready style handshake, and flags words lost to overrun.

module flex_stp_framer #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           clear,
    input  logic                           shift_enable,
    input  logic                           serial_in,
    input  logic                           rd_ready,
    output logic [NUM_BITS-1:0]            parallel_out,
    output logic [NUM_BITS-1:0]            word_out,
    output logic                           word_valid,
    output logic [$clog2(NUM_BITS)-1:0]    bit_count,
    output logic                           overrun
);

    localparam int CNT_W = $clog2(NUM_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t            buf_state;
    logic [NUM_BITS-1:0]   shift_reg;
    logic [NUM_BITS-1:0]   next_shift;
    logic                  shift_cycle;
    logic                  completing;

    assign parallel_out = shift_reg;
    assign word_valid   = (buf_state == FULL);
    assign shift_cycle  = shift_enable & ~clear;
    assign completing   = shift_cycle & (bit_count == LAST_CNT);

    // The post-shift register value, used both for the shift register itself and
    // for capturing a completed word on the same edge.
    always_comb begin
        next_shift = shift_reg;
        if (SHIFT_MSB) begin
            next_shift = {shift_reg[NUM_BITS-2:0], serial_in};
        end else begin
            next_shift = {serial_in, shift_reg[NUM_BITS-1:1]};
        end
    end

    // Shift register and bit counter; the counter wraps at the word length, not
    // at the counter's natural power-of-two limit, so words run back to back.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_reg <= '1;
            bit_count <= '0;
        end else if (clear) begin
            shift_reg <= '1;
            bit_count <= '0;
        end else if (shift_enable) begin
            shift_reg <= next_shift;
            if (bit_count == LAST_CNT) begin
                bit_count <= '0;
            end else begin
                bit_count <= bit_count + CNT_W'(1);
            end
        end
    end

    // Output buffer state machine: holds one completed word until the consumer
    // takes it; a word completing while the buffer is full and not being read is
    // dropped and latches the sticky overrun flag until clear or reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_state <= EMPTY;
            word_out  <= '1;
            overrun   <= 1'b0;
        end else if (clear) begin
            buf_state <= EMPTY;
            overrun   <= 1'b0;
        end else begin
            case (buf_state)
                EMPTY: begin
                    if (completing) begin
                        word_out  <= next_shift;
                        buf_state <= FULL;
                    end
                end
                FULL: begin
                    if (completing) begin
                        if (rd_ready) begin
                            word_out <= next_shift;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (rd_ready) begin
                        buf_state <= EMPTY;
                    end
                end
                default: begin
                    buf_state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flex_stp_framer.sv
// tb_flex_stp_framer: directed-vector bench for flex_stp_framer. Three instances
// share one set of inputs: 8-bit MSB-first, 8-bit LSB-first and 2-bit MSB-first.

module tb_flex_stp_framer;

    logic clk;
    logic n_rst;
    logic clear;
    logic shift_enable;
    logic serial_in;
    logic rd_ready;

    logic [7:0] m_par, m_word;
    logic       m_valid, m_ovr;
    logic [2:0] m_cnt;

    logic [7:0] l_par, l_word;
    logic       l_valid, l_ovr;
    logic [2:0] l_cnt;

    logic [1:0] t_par, t_word;
    logic       t_valid, t_ovr;
    logic [0:0] t_cnt;

    int checkCount;
    int passCount;

    flex_stp_framer #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) dut_msb (
        .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .rd_ready(rd_ready), .parallel_out(m_par),
        .word_out(m_word), .word_valid(m_valid), .bit_count(m_cnt), .overrun(m_ovr)
    );

    flex_stp_framer #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) dut_lsb (
        .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .rd_ready(rd_ready), .parallel_out(l_par),
        .word_out(l_word), .word_valid(l_valid), .bit_count(l_cnt), .overrun(l_ovr)
    );

    flex_stp_framer #(.NUM_BITS(2), .SHIFT_MSB(1'b1)) dut_two (
        .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .rd_ready(rd_ready), .parallel_out(t_par),
        .word_out(t_word), .word_valid(t_valid), .bit_count(t_cnt), .overrun(t_ovr)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and tally it.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then return 1 ns after it
    // with the inputs back at idle.
    task automatic applyStimulus(input logic se, input logic si, input logic rr,
                                 input logic cl);
        shift_enable = se;
        serial_in    = si;
        rd_ready     = rr;
        clear        = cl;
        @(posedge clk);
        #1;
        shift_enable = 1'b0;
        serial_in    = 1'b0;
        rd_ready     = 1'b0;
        clear        = 1'b0;
    endtask

    // Shift eight bits of w, MSB first or LSB first; rd_ready optionally on the
    // completing shift only.
    task automatic shiftByte(input logic [7:0] w, input bit msbFirst, input bit rdOnLast);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, msbFirst ? w[7-i] : w[i], (rdOnLast && i == 7), 1'b0);
        end
    endtask

    initial begin
        checkCount   = 0;
        passCount    = 0;
        n_rst        = 1'b0;
        clear        = 1'b0;
        shift_enable = 1'b0;
        serial_in    = 1'b0;
        rd_ready     = 1'b0;

        #12;
        checkOutput("reset_par",   m_par,   8'hFF);
        checkOutput("reset_word",  m_word,  8'hFF);
        checkOutput("reset_valid", m_valid, 1'b0);
        checkOutput("reset_cnt",   m_cnt,   3'd0);
        checkOutput("reset_ovr",   m_ovr,   1'b0);
        checkOutput("reset_two_word", t_word, 2'b11);
        @(negedge clk);
        n_rst = 1'b1;

        // MSB-first word 0xA5
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, (i % 2 == 0), 1'b0, 1'b0);
        checkOutput("msb_cnt_mid",   m_cnt,   3'd4);
        checkOutput("msb_valid_mid", m_valid, 1'b0);
        checkOutput("msb_par_mid",   m_par,   8'hFA);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("msb_a5_word",  m_word,  8'hA5);
        checkOutput("msb_a5_valid", m_valid, 1'b1);
        checkOutput("msb_a5_cnt",   m_cnt,   3'd0);
        checkOutput("msb_a5_par",   m_par,   8'hA5);

        // Read drains the buffer; a read while empty changes nothing
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("read_valid", m_valid, 1'b0);
        checkOutput("read_word",  m_word,  8'hA5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("read_empty_valid", m_valid, 1'b0);
        checkOutput("read_empty_ovr",   m_ovr,   1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // LSB-first word 0x3C
        shiftByte(8'h3C, 1'b0, 1'b0);
        checkOutput("lsb_3c_word",  l_word,  8'h3C);
        checkOutput("lsb_3c_valid", l_valid, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_lsb_valid", l_valid, 1'b0);
        checkOutput("clr_lsb_word",  l_word,  8'h3C);
        checkOutput("clr_lsb_par",   l_par,   8'hFF);

        // Bit order: a lone 1 followed by seven 0s
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("order_lsb", l_word, 8'h01);
        checkOutput("order_msb", m_word, 8'h80);

        // Overrun: 0x11 unread, then 0x22 completes without a read
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        shiftByte(8'h11, 1'b1, 1'b0);
        checkOutput("ovr_first_word", m_word, 8'h11);
        shiftByte(8'h22, 1'b1, 1'b0);
        checkOutput("ovr_word",  m_word,  8'h11);
        checkOutput("ovr_valid", m_valid, 1'b1);
        checkOutput("ovr_flag",  m_ovr,   1'b1);
        checkOutput("ovr_par",   m_par,   8'h22);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("ovr_read_valid", m_valid, 1'b0);
        checkOutput("ovr_sticky",     m_ovr,   1'b1);

        // Read on the completing shift replaces the held word without overrun
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_ovr", m_ovr, 1'b0);
        shiftByte(8'h11, 1'b1, 1'b0);
        shiftByte(8'h22, 1'b1, 1'b1);
        checkOutput("swap_word",  m_word,  8'h22);
        checkOutput("swap_valid", m_valid, 1'b1);
        checkOutput("swap_ovr",   m_ovr,   1'b0);

        // Clear mid-word overrides shift_enable
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_clr_cnt", m_cnt, 3'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_cnt",   m_cnt,   3'd0);
        checkOutput("clr_par",   m_par,   8'hFF);
        checkOutput("clr_valid", m_valid, 1'b0);
        shiftByte(8'h5A, 1'b1, 1'b0);
        checkOutput("after_clr_word", m_word, 8'h5A);

        // Build up an overrun, then reset asynchronously mid-word
        shiftByte(8'h00, 1'b1, 1'b0);
        checkOutput("pre_rst_ovr", m_ovr, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        checkOutput("arst_par",   m_par,   8'hFF);
        checkOutput("arst_word",  m_word,  8'hFF);
        checkOutput("arst_valid", m_valid, 1'b0);
        checkOutput("arst_cnt",   m_cnt,   3'd0);
        checkOutput("arst_ovr",   m_ovr,   1'b0);
        checkOutput("arst_two_word", t_word, 2'b11);
        checkOutput("arst_two_cnt",  t_cnt,  1'b0);
        #3;
        n_rst = 1'b1;

        // 2-bit instance framing 1,0 while the 8-bit one starts 0xA5 afresh
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("two_cnt_1", t_cnt, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("two_cnt_0", t_cnt,   1'b0);
        checkOutput("two_word",  t_word,  2'b10);
        checkOutput("two_valid", t_valid, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("post_rst_valid_mid", m_valid, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("post_rst_word",  m_word,  8'hA5);
        checkOutput("post_rst_valid", m_valid, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
